ddr_host_arbiter: RTL and testbench

- Shares the DDR controller's single host command port among NREQ requesters.
- Arbitrates round-robin with bounded row-hit preference on row = addr[15:12].
- Enforces a minimum inter-command gap and honours controller back-pressure.
- Tracks outstanding reads in an ID FIFO and routes read data back to the originating requester.
- Sits between the client blocks and the controller's cmd_n/rd_wr/addr_in/data_in/data_out interface.

---
 rtl/ddr_arb_pkg.sv | 11 +
 rtl/ddr_arb_idfifo.sv | 50 +++++
 rtl/ddr_host_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ddr_host_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR host-port arbiter.
package ddr_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} arb_state_e;

    localparam int   ROW_MSB   = 15;
    localparam int   ROW_LSB   = 12;
    localparam int   ADDR_W    = 16;
    localparam int   DATA_W    = 32;
    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;
endpackage

// File: rtl/ddr_arb_idfifo.sv
// Small FIFO holding requester IDs of reads still awaiting controller data.
module ddr_arb_idfifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/ddr_host_arbiter.sv
// Round-robin arbiter with bounded row-hit preference in front of a single DDR
// controller command port; routes read data back through an ID FIFO.
module ddr_host_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int RDQ_DEPTH      = 8,
    parameter int MAX_HIT_STREAK = 4,
    parameter int CMD_GAP        = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NREQ-1:0]                   req_vld,
    input  logic [NREQ-1:0]                   req_rd_wr,
    input  logic [NREQ-1:0][ADDR_W-1:0]       req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0]       req_wdata,
    output logic [NREQ-1:0]                   req_rdy,
    output logic [NREQ-1:0]                   rsp_vld,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic                              cmd_n,
    output logic                              rd_wr,
    output logic [ADDR_W-1:0]                 addr_in,
    output logic [DATA_W-1:0]                 data_in,
    input  logic                              ctrl_busy,
    input  logic                              data_out_vld,
    input  logic [DATA_W-1:0]                 data_out,
    output logic [$clog2(RDQ_DEPTH):0]        rdq_count,
    output logic                              rsp_err
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int SW    = PTR_W + 1;
    localparam int ROW_W = ROW_MSB - ROW_LSB + 1;
    localparam int HS_W  = $clog2(MAX_HIT_STREAK + 1);
    localparam int GAP_W = 4;
    localparam logic [HS_W-1:0] HS_MAX = HS_W'(MAX_HIT_STREAK);

    arb_state_e        state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HS_W-1:0]   hit_streak_q, hit_streak_d;
    logic [ROW_W-1:0]  last_row_q, last_row_d;
    logic              last_row_vld_q, last_row_vld_d;
    logic              cmd_n_q, cmd_n_d, rd_wr_q, rd_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
    logic [NREQ-1:0]   rsp_vld_q, rsp_vld_d;
    logic              rsp_err_q, rsp_err_d;
    logic              run_q;

    logic [NREQ-1:0]   elig, hit, cand;
    logic              use_hit, gnt_found, gnt;
    logic [PTR_W-1:0]  gnt_idx;
    logic [SW-1:0]     scan;
    logic              push, pop, rdq_full, rdq_empty;
    logic [PTR_W-1:0]  rdq_head;

    ddr_arb_idfifo #(.DEPTH(RDQ_DEPTH), .WIDTH(PTR_W)) u_idfifo (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .push_i  (push),
        .din_i   (gnt_idx),
        .pop_i   (pop),
        .dout_o  (rdq_head),
        .full_o  (rdq_full),
        .empty_o (rdq_empty),
        .count_o (rdq_count)
    );

    always_comb begin
        elig      = '0;
        hit       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_vld[i] && (req_rd_wr[i] == CMD_WRITE || !rdq_full);
            hit[i]  = elig[i] && last_row_vld_q && (req_addr[i][ROW_MSB:ROW_LSB] == last_row_q);
        end
        use_hit = (hit_streak_q < HS_MAX) && (|hit);
        cand    = use_hit ? hit : elig;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr_q} + SW'(k);
            if (scan >= SW'(NREQ)) scan = scan - SW'(NREQ);
            if (!gnt_found && cand[scan[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan[PTR_W-1:0];
            end
        end
        // run_q keeps req_rdy low while reset is held without mixing reset into data paths.
        gnt     = run_q && (state_q == IDLE) && !ctrl_busy && gnt_found;
        req_rdy = '0;
        if (gnt) req_rdy[gnt_idx] = 1'b1;
    end

    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        rr_ptr_d       = rr_ptr_q;
        hit_streak_d   = hit_streak_q;
        last_row_d     = last_row_q;
        last_row_vld_d = last_row_vld_q;
        cmd_n_d        = cmd_n_q;
        rd_wr_d        = rd_wr_q;
        addr_d         = addr_q;
        data_d         = data_q;
        push           = 1'b0;
        unique case (state_q)
            IDLE: if (gnt) begin
                state_d        = ISSUE;
                cmd_n_d        = 1'b0;
                rd_wr_d        = req_rd_wr[gnt_idx];
                addr_d         = req_addr[gnt_idx];
                if (req_rd_wr[gnt_idx] == CMD_WRITE) data_d = req_wdata[gnt_idx];
                rr_ptr_d       = (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                hit_streak_d   = !hit[gnt_idx] ? '0 :
                                 (hit_streak_q == HS_MAX) ? HS_MAX : hit_streak_q + 1'b1;
                last_row_d     = req_addr[gnt_idx][ROW_MSB:ROW_LSB];
                last_row_vld_d = 1'b1;
                push           = (req_rd_wr[gnt_idx] == CMD_READ);
            end
            ISSUE: begin
                state_d = GAP;
                cmd_n_d = 1'b1;
                gap_d   = GAP_W'(CMD_GAP);
            end
            GAP: begin
                if (gap_q <= GAP_W'(1)) state_d = IDLE;
                else                    gap_d   = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data from the controller returns in issue order; the FIFO head names its owner.
    always_comb begin
        pop        = data_out_vld && !rdq_empty;
        rsp_vld_d  = '0;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q || (data_out_vld && rdq_empty);
        if (pop) begin
            rsp_vld_d[rdq_head] = 1'b1;
            rsp_data_d          = data_out;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q        <= IDLE;
            gap_q          <= '0;
            rr_ptr_q       <= '0;
            hit_streak_q   <= '0;
            last_row_q     <= '0;
            last_row_vld_q <= 1'b0;
            cmd_n_q        <= 1'b1;
            rd_wr_q        <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            rsp_vld_q      <= '0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            run_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            rr_ptr_q       <= rr_ptr_d;
            hit_streak_q   <= hit_streak_d;
            last_row_q     <= last_row_d;
            last_row_vld_q <= last_row_vld_d;
            cmd_n_q        <= cmd_n_d;
            rd_wr_q        <= rd_wr_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            rsp_vld_q      <= rsp_vld_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            run_q          <= 1'b1;
        end
    end

    assign cmd_n    = cmd_n_q;
    assign rd_wr    = rd_wr_q;
    assign addr_in  = addr_q;
    assign data_in  = data_q;
    assign rsp_vld  = rsp_vld_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
endmodule

// File: tb/tb_ddr_host_arbiter.sv
// Directed bench for ddr_host_arbiter: grants, spacing, row hits, read routing, FIFO full, reset.
module tb_ddr_host_arbiter;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_vld, req_rd_wr, req_rdy, rsp_vld;
    logic [3:0][15:0]  req_addr;
    logic [3:0][31:0]  req_wdata;
    logic [31:0]       rsp_data, data_in, data_out;
    logic              cmd_n, rd_wr, ctrl_busy, data_out_vld, rsp_err;
    logic [15:0]       addr_in;
    logic [3:0]        rdq_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ddr_host_arbiter #(.NREQ(4), .RDQ_DEPTH(8), .MAX_HIT_STREAK(4), .CMD_GAP(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rd_wr(req_rd_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .cmd_n(cmd_n), .rd_wr(rd_wr),
        .addr_in(addr_in), .data_in(data_in), .ctrl_busy(ctrl_busy),
        .data_out_vld(data_out_vld), .data_out(data_out),
        .rdq_count(rdq_count), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Samples mid-cycle for a grant; returns just after the grant edge (cycle N+1).
    task automatic wait_grant(input string tag, input int exp, output int at);
        logic [3:0] seen;
        seen = '0;
        at   = -1;
        for (int c = 0; c < 20 && seen == 4'b0; c++) begin
            @(negedge clk); #1;
            if (req_rdy != 4'b0) begin
                seen = req_rdy;
                at   = cyc;
            end
        end
        chk(tag, {28'b0, seen}, 32'(1 << exp));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n        = 1'b1;
        req_vld      = '0;
        req_rd_wr    = '0;
        req_addr     = '0;
        req_wdata    = '0;
        ctrl_busy    = 1'b0;
        data_out_vld = 1'b0;
        data_out     = '0;
        @(posedge clk); #1;
        rst_n = 1'b0;
    endtask

    initial begin
        int at, t0;
        int exp_o[5];
        int at_c[5];
        logic [3:0] acc;

        rst_n = 1'b1; req_vld = '1; req_rd_wr = '0; req_addr = '0; req_wdata = '0;
        ctrl_busy = 1'b0; data_out_vld = 1'b0; data_out = '0;
        #12;
        chk("rst_req_rdy", {28'b0, req_rdy}, 0);
        chk("rst_cmd_n", {31'b0, cmd_n}, 1);
        chk("rst_rd_wr", {31'b0, rd_wr}, 0);
        chk("rst_addr", {16'b0, addr_in}, 0);
        chk("rst_data", data_in, 0);
        chk("rst_rsp_vld", {28'b0, rsp_vld}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rdq", {28'b0, rdq_count}, 0);
        chk("rst_err", {31'b0, rsp_err}, 0);

        // Single write from requester 2, held off first by ctrl_busy.
        do_reset();
        ctrl_busy = 1'b1;
        req_vld[2] = 1'b1; req_rd_wr[2] = 1'b0;
        req_addr[2] = 16'h3010; req_wdata[2] = 32'hDEAD_BEEF;
        acc = '0;
        repeat (4) begin @(negedge clk); #1; acc |= req_rdy; end
        chk("busy_no_gnt", {28'b0, acc}, 0);
        @(posedge clk); #1;
        ctrl_busy = 1'b0;
        wait_grant("w1_gnt", 2, at);
        req_vld[2] = 1'b0;
        ctrl_busy  = 1'b1;
        chk("w1_cmd_n", {31'b0, cmd_n}, 0);
        chk("w1_rd_wr", {31'b0, rd_wr}, 0);
        chk("w1_addr", {16'b0, addr_in}, 32'h3010);
        chk("w1_data", data_in, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("w1_gap1", {31'b0, cmd_n}, 1);
        @(posedge clk); #1;
        chk("w1_gap2", {31'b0, cmd_n}, 1);
        chk("w1_rdq", {28'b0, rdq_count}, 0);
        ctrl_busy = 1'b0;

        // Round robin across four writes to distinct rows.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[i]  = {4'(i + 1), 12'h010};
            req_wdata[i] = 32'h100 + i;
        end
        req_vld = 4'hF;
        exp_o = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            wait_grant("rr_gnt", exp_o[k], at_c[k]);
            req_vld[exp_o[k]] = 1'b0;
            if (k == 1) req_vld[0] = 1'b1;
            if (k > 0) chk("rr_spacing", at_c[k] - at_c[k-1], 4);
        end

        // Row-hit preference bounded by the streak limit.
        do_reset();
        req_vld[3] = 1'b1; req_addr[3] = 16'h5000;
        wait_grant("hit_prime", 3, at);
        req_vld[1] = 1'b1; req_addr[1] = 16'h7000;
        exp_o = '{3, 3, 3, 3, 1};
        for (int k = 0; k < 5; k++) begin
            wait_grant("hit_gnt", exp_o[k], at);
            if (exp_o[k] == 1) req_vld[1] = 1'b0;
        end
        wait_grant("hit_after", 3, at);
        req_vld = '0;

        // Read routing back to requesters 1 then 3.
        do_reset();
        req_vld = 4'b1010; req_rd_wr = 4'b1010;
        req_addr[1] = 16'h1100; req_addr[3] = 16'h2200;
        wait_grant("rd_gnt1", 1, at);
        req_vld[1] = 1'b0;
        wait_grant("rd_gnt3", 3, at);
        req_vld[3] = 1'b0;
        chk("rd_rdq2", {28'b0, rdq_count}, 2);
        data_out_vld = 1'b1; data_out = 32'h1111;
        @(posedge clk); #1;
        data_out_vld = 1'b0;
        chk("rd_rsp1_vld", {28'b0, rsp_vld}, 32'b0010);
        chk("rd_rsp1_data", rsp_data, 32'h1111);
        chk("rd_rdq1", {28'b0, rdq_count}, 1);
        @(posedge clk); #1;
        chk("rd_rsp_idle", {28'b0, rsp_vld}, 0);
        data_out_vld = 1'b1; data_out = 32'h3333;
        @(posedge clk); #1;
        data_out_vld = 1'b0;
        chk("rd_rsp3_vld", {28'b0, rsp_vld}, 32'b1000);
        chk("rd_rsp3_data", rsp_data, 32'h3333);
        chk("rd_rdq0", {28'b0, rdq_count}, 0);

        // Fill the ID FIFO; writes still pass, reads wait for a pop.
        do_reset();
        req_vld[0] = 1'b1; req_rd_wr[0] = 1'b1; req_addr[0] = 16'h0040;
        for (int k = 0; k < 8; k++) wait_grant("fill_gnt", 0, at);
        chk("full_rdq8", {28'b0, rdq_count}, 8);
        req_vld[2] = 1'b1; req_rd_wr[2] = 1'b0; req_addr[2] = 16'h9000;
        wait_grant("full_wr_gnt", 2, at);
        req_vld[2] = 1'b0;
        acc = '0;
        repeat (6) begin @(negedge clk); #1; acc |= req_rdy; end
        chk("full_rd_blocked", {28'b0, acc}, 0);
        @(posedge clk); #1;
        data_out_vld = 1'b1; data_out = 32'hA5;
        @(posedge clk); #1;
        data_out_vld = 1'b0;
        chk("full_pop_vld", {28'b0, rsp_vld}, 32'b0001);
        chk("full_pop_rdq", {28'b0, rdq_count}, 7);
        wait_grant("refill_gnt", 0, at);
        chk("refill_rdq", {28'b0, rdq_count}, 8);
        req_vld = '0;

        // Orphan data with a same-cycle push, then async reset during GAP.
        do_reset();
        @(posedge clk); #1;
        t0 = cyc;
        req_vld[1] = 1'b1; req_rd_wr[1] = 1'b1; req_addr[1] = 16'h2000;
        data_out_vld = 1'b1; data_out = 32'hBAD;
        wait_grant("orph_gnt", 1, at);
        chk("orph_gnt_cycle", at, t0);
        data_out_vld = 1'b0; req_vld[1] = 1'b0;
        chk("orph_rsp_vld", {28'b0, rsp_vld}, 0);
        chk("orph_err", {31'b0, rsp_err}, 1);
        chk("orph_rdq", {28'b0, rdq_count}, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("arst_cmd_n", {31'b0, cmd_n}, 1);
        chk("arst_rdq", {28'b0, rdq_count}, 0);
        chk("arst_err", {31'b0, rsp_err}, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
